// File: rtl/delay_sum_beamformer_if.sv
// Stream interface of the delay-and-sum beamformer: per-channel sample
// input, delay programming, and the summed output with its status flags.
interface delay_sum_beamformer_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2048
);
    localparam int DELAY_W = $clog2(DEPTH);

    logic                        valid_in;
    logic [NUM_CH*DATA_W-1:0]    audio_in;
    logic [NUM_CH*DELAY_W-1:0]   delay_in;
    logic                        delay_load_in;
    logic [DATA_W-1:0]           audio_out;
    logic                        valid_out;
    logic                        primed_out;

    modport master (
        output valid_in, audio_in, delay_in, delay_load_in,
        input  audio_out, valid_out, primed_out
    );

    modport slave (
        input  valid_in, audio_in, delay_in, delay_load_in,
        output audio_out, valid_out, primed_out
    );
endinterface

// File: rtl/delay_sum_beamformer.sv
// N-channel delay-and-sum beamformer. Each channel keeps DEPTH samples of
// history in a circular RAM sharing one write pointer; a channel's delayed
// sample is read back, masked until enough history exists, summed exactly
// across channels and scaled down by NUM_CH. Latency is 3 cycles.
module delay_sum_beamformer #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2048
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    delay_sum_beamformer_if.slave   bf
);
    localparam int DELAY_W = $clog2(DEPTH);
    localparam int LOG_CH  = $clog2(NUM_CH);
    localparam int SUM_W   = DATA_W + LOG_CH;
    localparam int FILL_W  = DELAY_W + 1;

    // History storage; contents are never cleared, fill_q masks stale data.
    logic [DATA_W-1:0]        mem_q      [NUM_CH][DEPTH];
    logic [DATA_W-1:0]        rd_q       [NUM_CH];
    logic [DATA_W-1:0]        byp_q      [NUM_CH];

    logic [DELAY_W-1:0]       wptr_q, wptr_d;
    logic [FILL_W-1:0]        fill_q, fill_d;
    logic [DELAY_W-1:0]       dly_q      [NUM_CH];
    logic [DELAY_W-1:0]       dly_d      [NUM_CH];
    logic [DELAY_W-1:0]       rd_addr_s  [NUM_CH];
    logic [DELAY_W-1:0]       max_dly_s;

    logic [NUM_CH-1:0]        sel_byp_q, sel_byp_d;
    logic [NUM_CH-1:0]        mask_q, mask_d;
    logic                     v1_q, v2_q;
    logic [DATA_W-1:0]        term_s     [NUM_CH];
    logic signed [SUM_W-1:0]  sum_q, sum_d;
    logic [DATA_W-1:0]        out_q, out_d;
    logic                     vout_q;
    logic                     primed_q, primed_d;

    // Read addresses, per-channel mask/bypass selects and delay-register next state.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            rd_addr_s[k] = wptr_q - dly_q[k];
            mask_d[k]    = (fill_q >= {1'b0, dly_q[k]});
            sel_byp_d[k] = (dly_q[k] == {DELAY_W{1'b0}});
            if (bf.delay_load_in) begin
                dly_d[k] = bf.delay_in[k*DELAY_W +: DELAY_W];
            end else begin
                dly_d[k] = dly_q[k];
            end
        end
    end

    // Write pointer advance and saturating history fill count.
    always_comb begin
        if (bf.valid_in) begin
            wptr_d = wptr_q + DELAY_W'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (bf.valid_in && (fill_q != FILL_W'(DEPTH))) begin
            fill_d = fill_q + FILL_W'(1);
        end else begin
            fill_d = fill_q;
        end
    end

    // Largest active delay decides whether every channel is contributing.
    always_comb begin
        max_dly_s = {DELAY_W{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            if (dly_q[k] > max_dly_s) begin
                max_dly_s = dly_q[k];
            end else begin
                max_dly_s = max_dly_s;
            end
        end
        primed_d = (fill_q >= {1'b0, max_dly_s});
    end

    // Select RAM or bypass data per channel, apply mask, sign-extend and sum exactly.
    always_comb begin
        sum_d = {SUM_W{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            if (!mask_q[k]) begin
                term_s[k] = {DATA_W{1'b0}};
            end else if (sel_byp_q[k]) begin
                term_s[k] = byp_q[k];
            end else begin
                term_s[k] = rd_q[k];
            end
            sum_d = sum_d + {{LOG_CH{term_s[k][DATA_W-1]}}, term_s[k]};
        end
    end

    // Output scaling by arithmetic shift (floor); hold value between valid samples.
    always_comb begin
        if (v2_q) begin
            out_d = DATA_W'(sum_q >>> LOG_CH);
        end else begin
            out_d = out_q;
        end
    end

    // RAM write at wptr with read-first delayed read and bypass capture.
    always_ff @(posedge clk_in) begin
        if (bf.valid_in) begin
            for (int k = 0; k < NUM_CH; k++) begin
                rd_q[k]              <= mem_q[k][rd_addr_s[k]];
                mem_q[k][wptr_q]     <= bf.audio_in[k*DATA_W +: DATA_W];
                byp_q[k]             <= bf.audio_in[k*DATA_W +: DATA_W];
            end
        end
    end

    // Pointer, fill count and active delay registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wptr_q <= {DELAY_W{1'b0}};
            fill_q <= {FILL_W{1'b0}};
            for (int k = 0; k < NUM_CH; k++) begin
                dly_q[k] <= {DELAY_W{1'b0}};
            end
        end else begin
            wptr_q <= wptr_d;
            fill_q <= fill_d;
            for (int k = 0; k < NUM_CH; k++) begin
                dly_q[k] <= dly_d[k];
            end
        end
    end

    // Stage 1 control: mask and bypass selects travel with the read data.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            v1_q      <= 1'b0;
            mask_q    <= {NUM_CH{1'b0}};
            sel_byp_q <= {NUM_CH{1'b0}};
        end else begin
            v1_q <= bf.valid_in;
            if (bf.valid_in) begin
                mask_q    <= mask_d;
                sel_byp_q <= sel_byp_d;
            end
        end
    end

    // Stage 2 sum register and stage 3 output/status registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            v2_q     <= 1'b0;
            sum_q    <= {SUM_W{1'b0}};
            vout_q   <= 1'b0;
            out_q    <= {DATA_W{1'b0}};
            primed_q <= 1'b0;
        end else begin
            v2_q     <= v1_q;
            if (v1_q) begin
                sum_q <= sum_d;
            end
            vout_q   <= v2_q;
            out_q    <= out_d;
            primed_q <= primed_d;
        end
    end

    assign bf.audio_out  = out_q;
    assign bf.valid_out  = vout_q;
    assign bf.primed_out = primed_q;
endmodule

// File: tb/tb_delay_sum_beamformer.sv
// Self-checking bench for delay_sum_beamformer. A sample-indexed history
// model computes each expected output directly from the delay-and-sum rule.
module tb_delay_sum_beamformer;
    localparam int NUM_CH  = 4;
    localparam int DATA_W  = 16;
    localparam int DEPTH   = 2048;
    localparam int DW      = $clog2(DEPTH);
    localparam int LOG_CH  = $clog2(NUM_CH);
    localparam int HMAX    = 16384;

    logic clk_in;
    logic rst_n_in;

    delay_sum_beamformer_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) bf ();

    delay_sum_beamformer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bf       (bf)
    );

    int checks;
    int errors;

    // Model state: every sample since reset, indexed by sample number.
    int hist [NUM_CH][HMAX];
    int d_m  [NUM_CH];
    int n_m;
    bit pv   [3];
    int pe   [3];
    int last_m;
    int got  [HMAX];
    int oi;

    int a_s  [NUM_CH];
    int dl_s [NUM_CH];

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < NUM_CH; k++) d_m[k] = 0;
        n_m = 0;
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0;
            pe[i] = 0;
        end
        last_m = 0;
        oi = 0;
    endtask

    // Drive one cycle of stimulus, advance the model, then check all outputs.
    task automatic step(input bit v, input bit ld);
        int md;
        int sum;
        bit p;
        md = 0;
        for (int k = 0; k < NUM_CH; k++) if (d_m[k] > md) md = d_m[k];
        p = (n_m >= md);
        bf.valid_in      = v;
        bf.delay_load_in = ld;
        for (int k = 0; k < NUM_CH; k++) begin
            bf.audio_in[k*DATA_W +: DATA_W] = DATA_W'(a_s[k]);
            bf.delay_in[k*DW +: DW]         = DW'(dl_s[k]);
        end
        sum = 0;
        if (v) begin
            for (int k = 0; k < NUM_CH; k++) hist[k][n_m] = a_s[k];
            for (int k = 0; k < NUM_CH; k++) begin
                if (n_m >= d_m[k]) sum += hist[k][n_m - d_m[k]];
            end
            n_m++;
        end
        if (ld) for (int k = 0; k < NUM_CH; k++) d_m[k] = dl_s[k];
        pv[2] = pv[1]; pv[1] = pv[0]; pv[0] = v;
        pe[2] = pe[1]; pe[1] = pe[0]; pe[0] = sum >>> LOG_CH;
        @(posedge clk_in);
        #1;
        chk("valid_out", {31'd0, bf.valid_out}, {31'd0, pv[2]});
        if (pv[2]) begin
            last_m = pe[2];
            got[oi] = $signed(bf.audio_out);
            oi++;
        end
        chk("audio_out", $signed(bf.audio_out), last_m);
        chk("primed_out", {31'd0, bf.primed_out}, {31'd0, p});
    endtask

    task automatic set_all(input int x);
        for (int k = 0; k < NUM_CH; k++) a_s[k] = x;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic plain_reset();
        rst_n_in = 1'b0;
        clear_model();
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_valid_out", {31'd0, bf.valid_out}, 32'sd0);
        chk("rst_audio_out", $signed(bf.audio_out), 32'sd0);
        chk("rst_primed_out", {31'd0, bf.primed_out}, 32'sd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bf.valid_in      = 1'b0;
        bf.delay_load_in = 1'b0;
        bf.audio_in      = '0;
        bf.delay_in      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            a_s[k]  = 0;
            dl_s[k] = 0;
        end
        rst_n_in = 1'b0;
        clear_model();
        #1;
        chk("por_valid_out", {31'd0, bf.valid_out}, 32'sd0);
        plain_reset();

        // All delays zero: plain average of the four channels.
        a_s[0] = 100; a_s[1] = 200; a_s[2] = 300; a_s[3] = 400;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        idle(3);
        chk("avg_250", got[0], 32'sd250);
        chk("avg_250_primed", {31'd0, bf.primed_out}, 32'sd1);

        // Signed arithmetic and floor rounding.
        set_all(-3);
        step(1'b1, 1'b0);
        a_s[0] = -1; a_s[1] = 0; a_s[2] = 0; a_s[3] = 0;
        step(1'b1, 1'b0);
        idle(3);
        chk("neg_sum", got[2], -32'sd3);
        chk("neg_floor", got[3], -32'sd1);

        // Random data with gaps, zero delays.
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < NUM_CH; k++) a_s[k] = int'($urandom_range(0, 65535)) - 32768;
            step($urandom_range(0, 3) != 0, 1'b0);
        end
        idle(3);

        // Staggered delays on a ramp, then a delay load coincident with a sample.
        plain_reset();
        dl_s[0] = 0; dl_s[1] = 1; dl_s[2] = 2; dl_s[3] = 3;
        step(1'b0, 1'b1);
        for (int n = 0; n < 28; n++) begin
            set_all(n);
            if (n == 20) begin
                dl_s[0] = 0; dl_s[1] = 0; dl_s[2] = 0; dl_s[3] = 5;
                step(1'b1, 1'b1);
            end else begin
                step(1'b1, 1'b0);
            end
        end
        idle(3);
        chk("ramp_n0", got[0], 32'sd0);
        chk("ramp_n3", got[3], 32'sd1);
        chk("ramp_n7", got[7], 32'sd5);
        chk("load_old_n20", got[20], 32'sd18);
        chk("load_new_n21", got[21], 32'sd19);
        chk("load_primed", {31'd0, bf.primed_out}, 32'sd1);

        // Random data, random gaps and random run-time delay loads.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                a_s[k]  = int'($urandom_range(0, 65535)) - 32768;
                dl_s[k] = ($urandom_range(0, 9) == 0) ? DEPTH - 1 : int'($urandom_range(0, 63));
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end
        idle(3);

        // Maximum delay across the write-pointer wrap.
        plain_reset();
        dl_s[0] = 1; dl_s[1] = 7; dl_s[2] = 0; dl_s[3] = DEPTH - 1;
        step(1'b0, 1'b1);
        for (int n = 0; n < 2 * DEPTH; n++) begin
            set_all(n % 32768);
            step(1'b1, 1'b0);
        end
        idle(3);
        chk("wrap_masked", got[DEPTH-2], 32'sd1532);
        chk("wrap_first", got[DEPTH-1], 32'sd1533);
        chk("wrap_last", got[2*DEPTH-1], 32'sd3581);

        // Asynchronous reset with two samples in flight.
        for (int k = 0; k < NUM_CH; k++) a_s[k] = int'($urandom_range(0, 1000));
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        rst_n_in = 1'b0;
        bf.valid_in = 1'b0;
        clear_model();
        #1;
        chk("async_valid_out", {31'd0, bf.valid_out}, 32'sd0);
        chk("async_audio_out", $signed(bf.audio_out), 32'sd0);
        chk("async_primed_out", {31'd0, bf.primed_out}, 32'sd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in);
            #1;
            chk("inrst_valid_out", {31'd0, bf.valid_out}, 32'sd0);
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        idle(4);
        dl_s[0] = 0; dl_s[1] = 1; dl_s[2] = 1; dl_s[3] = 1;
        step(1'b0, 1'b1);
        a_s[0] = 10; a_s[1] = 20; a_s[2] = 30; a_s[3] = 40;
        step(1'b1, 1'b0);
        idle(3);
        chk("post_rst_masked", got[0], 32'sd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
